// File: rtl/histogram_msg_pkg.sv
// rtl/histogram_msg_pkg.sv - shared constants and state encoding for histogram message formatter/decoder
package histogram_msg_pkg;

  localparam logic [7:0] CHR_SP = 8'h20;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_CR = 8'h0D;

  typedef enum logic {
    S_DIGIT = 1'b0,
    S_SKIP  = 1'b1
  } state_t;

  function automatic int hex_digits(input int width);
    return width / 4;
  endfunction

endpackage

// File: rtl/hex_char_decode.sv
// rtl/hex_char_decode.sv - ASCII hex character (0-9, A-F, a-f) to nibble
module hex_char_decode (
  input  logic [7:0] I_CHR,
  output logic [3:0] O_NIB,
  output logic       O_VLD
);

  always_comb begin
    O_NIB = 4'd0;
    O_VLD = 1'b0;
    if (I_CHR >= 8'h30 && I_CHR <= 8'h39) begin
      O_NIB = I_CHR[3:0];
      O_VLD = 1'b1;
    end else if ((I_CHR >= 8'h41 && I_CHR <= 8'h46) ||
                 (I_CHR >= 8'h61 && I_CHR <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
      O_NIB = I_CHR[3:0] + 4'd9;
      O_VLD = 1'b1;
    end
  end

endmodule

// File: rtl/histogram_msg_decoder.sv
// rtl/histogram_msg_decoder.sv - ASCII histogram frame decoder with shadowed output vector
// Optional error counter port ERR_CNT enabled by HISTOGRAM_MSG_DECODER_ERRCNT_EN.
module histogram_msg_decoder
  import histogram_msg_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int COUNT = 32
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   I_STB,
  input  logic [7:0]             I_DAT,
  output logic                   O_STB,
  output logic [COUNT*WIDTH-1:0] O_DAT,
  output logic                   O_ERR
`ifdef HISTOGRAM_MSG_DECODER_ERRCNT_EN
  ,
  output logic [15:0]            ERR_CNT
`endif
);

  localparam int NDIG = hex_digits(WIDTH);
  localparam int IDXW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int DCW  = $clog2(NDIG + 1);
  localparam logic [DCW-1:0]  NDIG_C   = DCW'(NDIG);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(COUNT - 1);

  state_t                 state;
  logic [COUNT*WIDTH-1:0] work;
  logic [WIDTH-1:0]       acc;
  logic [IDXW-1:0]        word_idx;
  logic [DCW-1:0]         dig_cnt;
  logic [3:0]             nib;
  logic                   nib_vld;
  logic                   dig_full;

  hex_char_decode u_hex (
    .I_CHR (I_DAT),
    .O_NIB (nib),
    .O_VLD (nib_vld)
  );

  assign dig_full = (dig_cnt == NDIG_C);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state    <= S_DIGIT;
      work     <= '0;
      acc      <= '0;
      word_idx <= '0;
      dig_cnt  <= '0;
      O_STB    <= 1'b0;
      O_ERR    <= 1'b0;
      O_DAT    <= '0;
    end else begin
      O_STB <= 1'b0;
      O_ERR <= 1'b0;
      if (I_STB && I_DAT != CHR_CR) begin
        case (state)
          S_DIGIT: begin
            if (nib_vld) begin
              if (!dig_full) begin
                acc     <= {acc[WIDTH-5:0], nib};
                dig_cnt <= dig_cnt + DCW'(1);
              end else begin
                O_ERR <= 1'b1;
                state <= S_SKIP;
              end
            end else if (I_DAT == CHR_SP) begin
              if (dig_full && word_idx != LAST_IDX) begin
                work[word_idx*WIDTH +: WIDTH] <= acc;
                word_idx <= word_idx + IDXW'(1);
                dig_cnt  <= '0;
              end else begin
                O_ERR <= 1'b1;
                state <= S_SKIP;
              end
            end else if (I_DAT == CHR_LF) begin
              // Last word goes straight from acc into the shadow; work keeps slots 0..COUNT-2
              if (dig_full && word_idx == LAST_IDX) begin
                O_DAT <= {acc, work[(COUNT-1)*WIDTH-1:0]};
                O_STB <= 1'b1;
              end else begin
                O_ERR <= 1'b1;
              end
              word_idx <= '0;
              dig_cnt  <= '0;
            end else begin
              O_ERR <= 1'b1;
              state <= S_SKIP;
            end
          end
          S_SKIP: begin
            if (I_DAT == CHR_LF) begin
              state    <= S_DIGIT;
              word_idx <= '0;
              dig_cnt  <= '0;
            end
          end
          default: state <= S_SKIP;
        endcase
      end
    end
  end

`ifdef HISTOGRAM_MSG_DECODER_ERRCNT_EN
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ERR_CNT <= '0;
    end else if (O_ERR && ERR_CNT != 16'hFFFF) begin
      ERR_CNT <= ERR_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_histogram_msg_decoder.sv
// tb/tb_histogram_msg_decoder.sv - scoreboard bench for histogram_msg_decoder
module tb_histogram_msg_decoder;

  localparam int WIDTH = 24;
  localparam int COUNT = 32;
  localparam int NDIG  = WIDTH / 4;
  localparam int VW    = WIDTH * COUNT;

  typedef logic [7:0] u8;
  typedef struct {
    logic [VW-1:0] data;
    int            cyc;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          I_STB;
  logic [7:0]    I_DAT;
  logic          O_STB;
  logic [VW-1:0] O_DAT;
  logic          O_ERR;
`ifdef HISTOGRAM_MSG_DECODER_ERRCNT_EN
  logic [15:0]   ERR_CNT;
`endif

  histogram_msg_decoder #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .I_STB (I_STB),
    .I_DAT (I_DAT),
    .O_STB (O_STB),
    .O_DAT (O_DAT),
    .O_ERR (O_ERR)
`ifdef HISTOGRAM_MSG_DECODER_ERRCNT_EN
    ,
    .ERR_CNT (ERR_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  exp_t          exp_q[$];
  u8             line[$];
  int            byte_cyc[$];
  logic [VW-1:0] shadow = '0;
  int            exp_err = 0;
  int            err_seen = 0;
  int            hw_err = 0;
  int            last_err_cyc = -1;
  bit            mon_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int hexval(input u8 b);
    if (b >= "0" && b <= "9") return int'(b) - int'("0");
    if (b >= "A" && b <= "F") return int'(b) - int'("A") + 10;
    if (b >= "a" && b <= "f") return int'(b) - int'("a") + 10;
    return -1;
  endfunction

  function automatic u8 hexchr(input int n, input bit lower);
    if (n < 10) return u8'(int'("0") + n);
    return lower ? u8'(int'("a") + n - 10) : u8'(int'("A") + n - 10);
  endfunction

  // A line is a frame iff it splits on spaces into exactly COUNT tokens of NDIG hex digits
  function automatic bit line_ok(input u8 ln[$], output logic [VW-1:0] v);
    int ntok = 0;
    int len = 0;
    bit ok = 1'b1;
    logic [WIDTH-1:0] val = '0;
    v = '0;
    for (int i = 0; i <= ln.size(); i++) begin
      if (i == ln.size() || ln[i] == 8'h20) begin
        if (len != NDIG || ntok >= COUNT) ok = 1'b0;
        else v[ntok*WIDTH +: WIDTH] = val;
        ntok++;
        len = 0;
        val = '0;
      end else begin
        if (hexval(ln[i]) < 0) ok = 1'b0;
        else val = val * 16 + WIDTH'(hexval(ln[i]));
        len++;
      end
    end
    return ok && ntok == COUNT;
  endfunction

  task automatic send_byte(input u8 b, input int gap);
    logic [VW-1:0] v;
    I_STB = 1'b1;
    I_DAT = b;
    byte_cyc.push_back(cyc);
    if (b == 8'h0A) begin
      if (line_ok(line, v)) exp_q.push_back('{data: v, cyc: cyc + 1});
      else begin
        exp_err++;
        hw_err++;
      end
      line.delete();
    end else if (b != 8'h0D) begin
      line.push_back(b);
    end
    @(posedge CLK); #1;
    I_STB = 1'b0;
    repeat (gap) begin @(posedge CLK); #1; end
  endtask

  task automatic send_frame(input u8 q[$], input int maxgap);
    byte_cyc.delete();
    foreach (q[i]) send_byte(q[i], $urandom_range(0, maxgap));
  endtask

  task automatic make_frame(input logic [VW-1:0] v, input int lc, output u8 q[$]);
    q.delete();
    for (int k = 0; k < COUNT; k++) begin
      for (int d = NDIG - 1; d >= 0; d--)
        q.push_back(hexchr(int'(v[k*WIDTH + d*4 +: 4]), lc == 2 ? bit'($urandom_range(0, 1)) : bit'(lc)));
      if (k < COUNT - 1) q.push_back(8'h20);
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge CLK); #1; n++; end
    chk({name, "_pending_stb"}, exp_q.size(), 0);
    repeat (3) begin @(posedge CLK); #1; end
    chk({name, "_err_pulses"}, err_seen, exp_err);
`ifdef HISTOGRAM_MSG_DECODER_ERRCNT_EN
    chk({name, "_err_cnt"}, ERR_CNT, (hw_err > 65535) ? 65535 : hw_err);
`endif
  endtask

  task automatic do_reset();
    RSTN  = 1'b0;
    I_STB = 1'b0;
    @(posedge CLK); #1;
    RSTN = 1'b1;
    line.delete();
    shadow = '0;
    hw_err = 0;
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      exp_t e;
      chk("stb_err_exclusive", O_STB & O_ERR, 0);
      if (O_ERR) begin
        err_seen++;
        last_err_cyc = cyc;
      end
      if (O_STB) begin
        if (exp_q.size() == 0) chk("unexpected_stb", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("stb_latency", cyc, e.cyc);
          chk("frame_data", O_DAT, e.data);
          shadow = e.data;
        end
      end else begin
        chk("o_dat_hold", O_DAT, shadow);
      end
    end
  end

  initial begin
    logic [VW-1:0] s1;
    logic [VW-1:0] v;
    u8             q[$];
    u8             g[$];
    int            t;
    int            p;

    RSTN  = 1'b0;
    I_STB = 1'b0;
    I_DAT = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_o_stb", O_STB, 0);
    chk("reset_o_err", O_ERR, 0);
    chk("reset_o_dat", O_DAT, 0);
`ifdef HISTOGRAM_MSG_DECODER_ERRCNT_EN
    chk("reset_err_cnt", ERR_CNT, 0);
`endif
    RSTN   = 1'b1;
    mon_en = 1'b1;

    for (int k = 0; k < COUNT; k++) s1[k*WIDTH +: WIDTH] = WIDTH'(k);

    make_frame(s1, 0, q);
    send_frame(q, 0);
    drain("s1");

    make_frame(s1, 1, q);
    send_frame(q, 5);
    drain("s2");

    make_frame(s1, 0, q);
    q.delete(35);
    send_frame(q, 1);
    drain("s3_bad");
    chk("s3_err_at_space", last_err_cyc, byte_cyc[40] + 1);
    for (int k = 0; k < COUNT; k++) v[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    make_frame(v, 2, q);
    send_frame(q, 2);
    drain("s3_good");

    make_frame(s1, 0, q);
    repeat (7) q.delete(216);
    send_frame(q, 1);
    drain("s4_short");
    g = '{8'h30, 8'h30, 8'h47, 8'h31, 8'h32, 8'h20, 8'h78, 8'h0A};
    send_frame(g, 1);
    drain("s4_garbage");

    make_frame(s1, 0, q);
    for (int i = 0; i <= 76; i++) send_byte(q[i], $urandom_range(0, 1));
    do_reset();
    chk("s5_odat_cleared", O_DAT, 0);
    for (int i = 77; i < q.size(); i++) send_byte(q[i], $urandom_range(0, 1));
    drain("s5_remainder");
    make_frame(s1, 2, q);
    send_frame(q, 1);
    drain("s5_next");

    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < COUNT; k++) v[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      make_frame(v, 2, q);
      if ($urandom_range(0, 1) == 1) begin
        t = $urandom_range(0, 4);
        p = $urandom_range(0, q.size() - 2);
        case (t)
          0: q.delete(p);
          1: q.insert(p, hexchr($urandom_range(0, 15), 1'b0));
          2: q[p] = (($urandom_range(0, 255) == 10) ? 8'h3A : u8'($urandom_range(0, 255)));
          3: q.insert(p, 8'h20);
          default: q[p] = 8'h47;
        endcase
      end
      send_frame(q, 2);
      drain("random");
    end

`ifdef HISTOGRAM_MSG_DECODER_ERRCNT_EN
    for (int i = 0; i < 65540; i++) send_byte(8'h0A, 0);
    drain("s6_saturate");
    chk("s6_err_cnt_ffff", ERR_CNT, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
